// File: rtl/axib_pkg.sv
// Shared AXI codes, FSM state types and request checks for the bridge memory responder.
// No logic beyond a combinational helper; no latency, no flow control.
// Imported by every file of the responder.
package axib_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0] AXI_SIZE_FULL = 3'd5;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

    // Only full-width beats and FIXED/INCR addressing are served; WRAP walks like INCR.
    function automatic logic req_err(input logic oob, input logic [2:0] size, input logic [1:0] burst);
        return oob || (size != AXI_SIZE_FULL) || (burst == BURST_WRAP);
    endfunction

endpackage

// File: rtl/axib_ram.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// Read data appears 1 cycle after re; a same-cycle write to the read word returns old data.
// No backpressure; both ports accept every cycle.
module axib_ram #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 1024,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [BE_W-1:0]   wbe,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read and write share one process so the read samples pre-write contents.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axib_mem_responder.sv
// AXI4 responder serving bridge BAR accesses from an internal byte-writable RAM.
// AW->wready 1 cycle, last W->bvalid 1 cycle; AR->rvalid 2 cycles, one read beat per 2 cycles.
// B/R held stable until ready; W stalled outside a burst; one transaction per direction.
module axib_mem_responder import axib_pkg::*; #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 1024
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [ID_W-1:0]       s_axi_awid,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_W-1:0]       s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_W-1:0]       s_axi_arid,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_W-1:0]       s_axi_rid,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int IDX_W = $clog2(DEPTH);

    wr_state_t         wr_state, wr_next;
    rd_state_t         rd_state, rd_next;
    logic              live;
    logic [ID_W-1:0]   w_id, r_id;
    logic [IDX_W-1:0]  w_idx, r_idx;
    logic [7:0]        w_len, w_cnt, r_len, r_cnt;
    logic [1:0]        w_burst, r_burst;
    logic              w_err, r_err;
    logic [DATA_W-1:0] ram_q;
    logic              aw_hs, w_hs, ar_hs, r_hs;
    logic              w_final, w_beat_err, r_final;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, s_axi_awaddr[4:0], s_axi_araddr[4:0]};

    assign aw_hs      = s_axi_awvalid & s_axi_awready;
    assign w_hs       = s_axi_wvalid & s_axi_wready;
    assign ar_hs      = s_axi_arvalid & s_axi_arready;
    assign r_hs       = s_axi_rvalid & s_axi_rready;
    assign w_final    = (w_cnt == w_len);
    assign r_final    = (r_cnt == r_len);
    assign w_beat_err = (s_axi_wlast != w_final);

    // Holds address readies low while reset is asserted.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            live     <= 1'b0;
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            live     <= 1'b1;
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next       = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                s_axi_awready = live;
                if (aw_hs) wr_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (w_hs && (s_axi_wlast || w_final)) wr_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wr_next = W_IDLE;
            end
            default: wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_next       = rd_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_axi_arready = live;
                if (ar_hs) rd_next = R_FETCH;
            end
            R_FETCH: rd_next = R_DATA;
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) rd_next = r_final ? R_IDLE : R_FETCH;
            end
            default: rd_next = R_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= BURST_INCR;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= s_axi_awid;
            w_idx   <= s_axi_awaddr[5 +: IDX_W];
            w_len   <= s_axi_awlen;
            w_cnt   <= '0;
            w_burst <= s_axi_awburst;
            w_err   <= req_err(|s_axi_awaddr[ADDR_W-1:5+IDX_W], s_axi_awsize, s_axi_awburst);
        end else if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (w_burst != BURST_FIXED) w_idx <= w_idx + IDX_W'(1);
            if (w_beat_err) w_err <= 1'b1;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= BURST_INCR;
            r_err   <= 1'b0;
        end else if (ar_hs) begin
            r_id    <= s_axi_arid;
            r_idx   <= s_axi_araddr[5 +: IDX_W];
            r_len   <= s_axi_arlen;
            r_cnt   <= '0;
            r_burst <= s_axi_arburst;
            r_err   <= req_err(|s_axi_araddr[ADDR_W-1:5+IDX_W], s_axi_arsize, s_axi_arburst);
        end else if (r_hs && !r_final) begin
            r_cnt <= r_cnt + 8'd1;
            if (r_burst != BURST_FIXED) r_idx <= r_idx + IDX_W'(1);
        end
    end

    // The offending wlast beat of a malformed burst is dropped along with the rest.
    axib_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk   (axi_aclk),
        .we    (w_hs && !w_err && !w_beat_err),
        .waddr (w_idx),
        .wbe   (s_axi_wstrb),
        .wdata (s_axi_wdata),
        .re    (rd_state == R_FETCH),
        .raddr (r_idx),
        .rdata (ram_q)
    );

    assign s_axi_bid   = w_id;
    assign s_axi_bresp = w_err ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rid   = r_id;
    assign s_axi_rresp = r_err ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rlast = (rd_state == R_DATA) && r_final;
    assign s_axi_rdata = ((rd_state == R_DATA) && !r_err) ? ram_q : '0;

endmodule

// File: tb/tb_axib_mem_responder.sv
// Self-checking bench for axib_mem_responder with a word-array reference model.
module tb_axib_mem_responder;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int DEPTH  = 1024;
    localparam int IDX_W  = $clog2(DEPTH);

    logic                axi_aclk = 1'b0;
    logic                axi_aresetn = 1'b1;
    logic [ID_W-1:0]     s_axi_awid = '0;
    logic [ADDR_W-1:0]   s_axi_awaddr = '0;
    logic [7:0]          s_axi_awlen = '0;
    logic [2:0]          s_axi_awsize = '0;
    logic [1:0]          s_axi_awburst = '0;
    logic                s_axi_awvalid = 1'b0;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata = '0;
    logic [DATA_W/8-1:0] s_axi_wstrb = '0;
    logic                s_axi_wlast = 1'b0;
    logic                s_axi_wvalid = 1'b0;
    logic                s_axi_wready;
    logic [ID_W-1:0]     s_axi_bid;
    logic [1:0]          s_axi_bresp;
    logic                s_axi_bvalid;
    logic                s_axi_bready = 1'b0;
    logic [ID_W-1:0]     s_axi_arid = '0;
    logic [ADDR_W-1:0]   s_axi_araddr = '0;
    logic [7:0]          s_axi_arlen = '0;
    logic [2:0]          s_axi_arsize = '0;
    logic [1:0]          s_axi_arburst = '0;
    logic                s_axi_arvalid = 1'b0;
    logic                s_axi_arready;
    logic [ID_W-1:0]     s_axi_rid;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic [1:0]          s_axi_rresp;
    logic                s_axi_rlast;
    logic                s_axi_rvalid;
    logic                s_axi_rready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem_m [DEPTH];
    logic [DATA_W-1:0] wq [$];
    logic [31:0]       sq [$];

    always #5 axi_aclk = ~axi_aclk;

    axib_mem_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    function automatic bit start_err(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] burst);
        return (addr >= DEPTH * 32) || (size != 3'd5) || (burst == 2'd2);
    endfunction

    function automatic int beat_idx(input logic [31:0] addr, input logic [1:0] burst, input int beat);
        int s;
        s = int'(addr[5 +: IDX_W]);
        return (burst == 2'd0) ? s : (s + beat) % DEPTH;
    endfunction

    task automatic fill_beats(input int n, input bit full);
        logic [DATA_W-1:0] d;
        wq.delete();
        sq.delete();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
            wq.push_back(d);
            sq.push_back(full ? 32'hFFFF_FFFF : $urandom);
        end
    endtask

    // wl: 0 = wlast on beat len+1, -1 = wlast never set, k>0 = wlast on beat k.
    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int wl, input int bstall);
        int nb, bad, t, idx;
        bit err, serr;
        nb   = (wl > 0) ? wl : len + 1;
        bad  = (wl < 0) ? len + 1 : ((wl > 0 && wl != len + 1) ? wl : 0);
        serr = start_err(addr, size, burst);
        err  = serr || (bad != 0);
        @(negedge axi_aclk);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        #1;
        t = 0;
        while (!s_axi_awready && t < 50) begin @(negedge axi_aclk); #1; t++; end
        if (!s_axi_awready) begin
            checks++; errors++;
            $display("FAIL aw_timeout awready=%0b required=1", s_axi_awready);
            s_axi_awvalid = 1'b0;
            return;
        end
        @(negedge axi_aclk);
        s_axi_awvalid = 1'b0;
        for (int b = 1; b <= nb; b++) begin
            s_axi_wdata  = wq[b-1];
            s_axi_wstrb  = sq[b-1];
            s_axi_wlast  = (wl > 0) ? (b == wl) : ((wl == 0) && (b == len + 1));
            s_axi_wvalid = 1'b1;
            #1;
            if (b == 1) begin
                checks++;
                if (s_axi_wready !== 1'b1) begin
                    errors++;
                    $display("FAIL aw_to_wready wready=%0b required=1", s_axi_wready);
                end
            end
            t = 0;
            while (!s_axi_wready && t < 50) begin @(negedge axi_aclk); #1; t++; end
            if (!s_axi_wready) begin
                checks++; errors++;
                $display("FAIL w_timeout beat=%0d wready=%0b required=1", b, s_axi_wready);
                s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
                return;
            end
            if (!serr && (bad == 0 || b < bad)) begin
                idx = beat_idx(addr, burst, b - 1);
                for (int k = 0; k < 32; k++)
                    if (sq[b-1][k]) mem_m[idx][k*8 +: 8] = wq[b-1][k*8 +: 8];
            end
            @(negedge axi_aclk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        #1;
        checks++;
        if (s_axi_wready !== 1'b0) begin
            errors++;
            $display("FAIL wready_after_last got=%0b required=0", s_axi_wready);
        end
        for (int s = 0; s <= bstall; s++) begin
            checks++;
            if (s_axi_bvalid !== 1'b1 || s_axi_bid !== id || s_axi_bresp !== (err ? 2'b10 : 2'b00)) begin
                errors++;
                $display("FAIL b_resp cyc=%0d bvalid=%0b bid=%0h bresp=%0b required 1/%0h/%0b",
                         s, s_axi_bvalid, s_axi_bid, s_axi_bresp, id, err ? 2'b10 : 2'b00);
            end
            if (s < bstall) begin @(negedge axi_aclk); #1; end
        end
        s_axi_bready = 1'b1;
        @(negedge axi_aclk);
        s_axi_bready = 1'b0;
        #1;
        checks++;
        if (s_axi_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL b_drop bvalid=%0b required=0", s_axi_bvalid);
        end
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int rstall);
        int t;
        bit err;
        logic [DATA_W-1:0] exp;
        err = start_err(addr, size, burst);
        @(negedge axi_aclk);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        #1;
        t = 0;
        while (!s_axi_arready && t < 50) begin @(negedge axi_aclk); #1; t++; end
        if (!s_axi_arready) begin
            checks++; errors++;
            $display("FAIL ar_timeout arready=%0b required=1", s_axi_arready);
            s_axi_arvalid = 1'b0;
            return;
        end
        @(negedge axi_aclk);
        s_axi_arvalid = 1'b0;
        #1;
        for (int b = 1; b <= len + 1; b++) begin
            t = 1;
            while (!s_axi_rvalid && t < 50) begin @(negedge axi_aclk); #1; t++; end
            checks++;
            if (t != 2) begin
                errors++;
                $display("FAIL r_latency beat=%0d cycles=%0d required=2", b, t);
            end
            if (!s_axi_rvalid) return;
            exp = err ? '0 : mem_m[beat_idx(addr, burst, b - 1)];
            for (int s = 0; s <= rstall; s++) begin
                checks++;
                if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp || s_axi_rid !== id ||
                    s_axi_rresp !== (err ? 2'b10 : 2'b00) || s_axi_rlast !== (b == len + 1)) begin
                    errors++;
                    $display("FAIL r_beat beat=%0d cyc=%0d rvalid=%0b rid=%0h rresp=%0b rlast=%0b rdata=%h required rid=%0h rresp=%0b rlast=%0b rdata=%h",
                             b, s, s_axi_rvalid, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rdata,
                             id, err ? 2'b10 : 2'b00, b == len + 1, exp);
                end
                if (s < rstall) begin @(negedge axi_aclk); #1; end
            end
            s_axi_rready = 1'b1;
            @(negedge axi_aclk);
            s_axi_rready = 1'b0;
            #1;
        end
    endtask

    task automatic test_reset;
        #2 axi_aresetn = 1'b0;
        #1;
        checks++;
        if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast} !== 6'b0 ||
            s_axi_bresp !== 2'b0 || s_axi_rresp !== 2'b0 || s_axi_bid !== '0 || s_axi_rid !== '0 ||
            s_axi_rdata !== '0) begin
            errors++;
            $display("FAIL reset_outputs aw/ar/w/b/r/last=%b bresp=%0b rresp=%0b bid=%0h rid=%0h required all zero",
                     {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast},
                     s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid);
        end
        repeat (2) @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        #1;
        checks++;
        if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release awready=%0b arready=%0b required 1/1", s_axi_awready, s_axi_arready);
        end
    endtask

    task automatic test_prefill;
        fill_beats(64, 1'b1);
        do_write(4'h1, 32'h0, 63, 3'd5, 2'd1, 0, 0);
    endtask

    task automatic test_write_readback;
        wq = '{256'h11, 256'h22, 256'h33, 256'h44};
        sq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        do_write(4'h5, 32'h40, 3, 3'd5, 2'd1, 0, 0);
        do_read(4'h9, 32'h40, 3, 3'd5, 2'd1, 0);
    endtask

    task automatic test_partial_strobe;
        wq = '{'1};
        sq = '{32'hFFFF_FFFF};
        do_write(4'h2, 32'h20, 0, 3'd5, 2'd1, 0, 0);
        wq = '{256'h0};
        sq = '{32'h0000_000F};
        do_write(4'h2, 32'h20, 0, 3'd5, 2'd1, 0, 0);
        checks++;
        if (mem_m[1] !== {{28{8'hFF}}, 32'h0}) begin
            errors++;
            $display("FAIL strobe_model got=%h required=%h", mem_m[1], {{28{8'hFF}}, 32'h0});
        end
        do_read(4'h3, 32'h20, 0, 3'd5, 2'd1, 0);
    endtask

    task automatic test_out_of_range;
        fill_beats(2, 1'b1);
        do_write(4'h6, DEPTH * 32, 1, 3'd5, 2'd1, 0, 0);
        do_read(4'h6, DEPTH * 32, 1, 3'd5, 2'd1, 0);
        do_read(4'h7, 32'h0, 1, 3'd5, 2'd1, 0);
    endtask

    task automatic test_wlast_errors;
        fill_beats(4, 1'b1);
        do_write(4'h3, 32'h200, 3, 3'd5, 2'd1, 2, 0);
        do_read(4'h3, 32'h200, 3, 3'd5, 2'd1, 0);
        fill_beats(2, 1'b1);
        do_write(4'h4, 32'h240, 1, 3'd5, 2'd1, -1, 0);
        do_read(4'h4, 32'h240, 1, 3'd5, 2'd1, 0);
    endtask

    task automatic test_backpressure;
        fill_beats(3, 1'b0);
        do_write(4'hA, 32'h300, 2, 3'd5, 2'd1, 0, 10);
        do_read(4'hB, 32'h300, 2, 3'd5, 2'd1, 10);
    endtask

    task automatic test_fixed;
        wq = '{256'hA, 256'hB, 256'hC};
        sq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        do_write(4'hC, 32'h100, 2, 3'd5, 2'd0, 0, 0);
        do_read(4'hD, 32'h100, 0, 3'd5, 2'd1, 0);
    endtask

    task automatic test_random;
        logic [31:0] addr;
        logic [2:0] size;
        logic [1:0] burst;
        int len, wl, r;
        for (int i = 0; i < 24; i++) begin
            len  = $urandom_range(0, 7);
            addr = 32'($urandom_range(0, 56)) * 32;
            if ($urandom_range(0, 9) == 0) addr = addr + DEPTH * 32;
            r = $urandom_range(0, 7);
            burst = (r == 0) ? 2'd0 : ((r == 6) ? 2'd2 : 2'd1);
            size  = (r == 7) ? 3'd4 : 3'd5;
            r = $urandom_range(0, 9);
            wl = (r == 0) ? -1 : ((r == 1) ? $urandom_range(1, len + 1) : 0);
            fill_beats(len + 1, $urandom_range(0, 1) == 1);
            do_write(4'($urandom), addr, len, size, burst, wl, $urandom_range(0, 2));
            do_read(4'($urandom), addr, len, size, burst, $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid_read;
        int t;
        @(negedge axi_aclk);
        s_axi_arid = 4'h8; s_axi_araddr = 32'h0; s_axi_arlen = 8'd7;
        s_axi_arsize = 3'd5; s_axi_arburst = 2'd1; s_axi_arvalid = 1'b1;
        @(negedge axi_aclk);
        s_axi_arvalid = 1'b0;
        #1;
        t = 0;
        while (!s_axi_rvalid && t < 20) begin @(negedge axi_aclk); #1; t++; end
        s_axi_rready = 1'b1;
        @(negedge axi_aclk);
        s_axi_rready = 1'b0;
        #1;
        while (!s_axi_rvalid && t < 20) begin @(negedge axi_aclk); #1; t++; end
        checks++;
        if (s_axi_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_read_pre rvalid=%0b required=1", s_axi_rvalid);
        end
        axi_aresetn = 1'b0;
        #1;
        checks++;
        if ({s_axi_rvalid, s_axi_bvalid, s_axi_wready, s_axi_rlast, s_axi_arready} !== 5'b0) begin
            errors++;
            $display("FAIL mid_read_reset r/b/w/last/ar=%b required=00000",
                     {s_axi_rvalid, s_axi_bvalid, s_axi_wready, s_axi_rlast, s_axi_arready});
        end
        @(negedge axi_aclk);
        axi_aresetn = 1'b1;
        @(negedge axi_aclk);
        #1;
        checks++;
        if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL mid_read_release arready=%0b rvalid=%0b required 1/0", s_axi_arready, s_axi_rvalid);
        end
        do_read(4'h8, 32'h0, 7, 3'd5, 2'd1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_prefill();
        test_write_readback();
        test_partial_strobe();
        test_out_of_range();
        test_wlast_errors();
        test_backpressure();
        test_fixed();
        test_random();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
